alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU (4-bit ALUOp, src1/src2, shamt -> result, Zero) between NUM_REQ requesters.
//   Requesters are, for example, the EX stage and a branch/address helper.
//   Round-robin grant, valid/ready request and response handshakes, registered operands and results.
//   Sits between the requesters and the single ALU instance in the pipeline top level.
// PARAMETERS
//   bit_size  32  datapath width of src1/src2/result
//   NUM_REQ   2   number of requesters (2..8); ID_W = max(1, $clog2(NUM_REQ))
// PORTS
//   clk          in   1               single clock; all state changes on posedge
//   rst          in   1               synchronous, active-high reset
//   req_valid    in   NUM_REQ         per-requester request valid
//   req_ready    out  NUM_REQ         one-hot accept pulse to the granted requester
//   req_op       in   4*NUM_REQ       ALUOp per requester; slice i = [4i+3:4i]
//   req_src1     in   bit_size*NUM_REQ  operand 1 per requester
//   req_src2     in   bit_size*NUM_REQ  operand 2 per requester
//   req_shamt    in   5*NUM_REQ       shift amount per requester
//   alu_op       out  4               to ALU ALUOp
//   alu_src1     out  bit_size        to ALU src1
//   alu_src2     out  bit_size        to ALU src2
//   alu_shamt    out  5               to ALU shamt
//   alu_result   in   bit_size        from ALU ALU_result
//   alu_zero     in   1               from ALU Zero
//   rsp_valid    out  1               response valid
//   rsp_ready    in   1               response consumer ready
//   rsp_id       out  ID_W            index of the requester that owns the response
//   rsp_result   out  bit_size        registered ALU result
//   rsp_zero     out  1               registered Zero
//   rsp_err      out  1               1 if op was 0 or 12..15 (unsupported)
// BEHAVIOUR
//   FSM states: IDLE -> EXEC -> RESP -> IDLE. Minimum 3 cycles per operation, no overlap.
//   - IDLE: if any req_valid, pick the winner by round-robin starting at rr_ptr.
//     Pulse req_ready[winner] combinationally this cycle (a request transfers when valid & ready).
//     Latch op/src1/src2/shamt/id into the operand register; go to EXEC.
//     If no req_valid, stay in IDLE with req_ready = 0.
//   - EXEC: drive alu_* from the operand register. Capture alu_result, alu_zero and the error flag
//     into the response register; rr_ptr <= (id+1) mod NUM_REQ; go to RESP.
//   - RESP: rsp_valid = 1. rsp_* remain stable until rsp_valid & rsp_ready; then go to IDLE.
//     req_ready is 0 throughout EXEC and RESP.
//   - alu_op = 0 whenever the state is not EXEC. alu_src*/alu_shamt hold the operand register.
//   - Latency: request accepted at cycle T -> rsp_valid at T+2 (with rsp_ready held high).
//   - Round-robin: the search order is rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1 -> 0.
//     rr_ptr = 0 after reset, so requester 0 has priority first.
//   - Unsupported op: forwarded unchanged to the ALU (which returns result 0, Zero 0); rsp_err = 1.
//   - req_valid dropped while not granted: legal, no effect. A request's payload must stay stable
//     while its req_valid is high and it is not yet granted.
//   - Reset (at any state, including mid-EXEC/RESP): state = IDLE, rr_ptr = 0, the in-flight op is
//     discarded. Outputs: rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_err = 0,
//     req_ready = 0, alu_op = 0, alu_src1 = alu_src2 = 0, alu_shamt = 0.
//   - Widths: no arithmetic here. Operands pass through unmodified; rr_ptr increment is ID_W wide,
//     with an explicit wrap at NUM_REQ.
// STRUCTURE
//   - Package alu_pkg: ALUOp constants ALU_NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOR=6, SLT=7,
//     SLL=8, SRL=9, BEQ=10, BNE=11; ALU_OP_MAX=11; FSM state encodings IDLE/EXEC/RESP.
//   - Sub-module rr_arbiter: inputs req[NUM_REQ] and ptr; outputs a one-hot grant and a grant
//     index. Purely combinational.
//   - The top level holds the FSM, the operand and response registers, and the operand muxes.
//   - The ALU is instantiated outside this block.
// TESTING (NUM_REQ=2, bit_size=32, bench models the ALU)
//   1. Reset, then req0 ADD src1=5 src2=7 at T
//      -> req_ready[0]=1 at T; rsp_valid at T+2 with id=0, result=12, zero=0, err=0.
//   2. Both requests valid continuously, rsp_ready=1
//      -> grants alternate 0,1,0,1; each grant is 3 cycles after the previous one.
//   3. req1 BEQ src1=src2=0x55
//      -> rsp_zero=1, rsp_result=0, rsp_id=1.
//   4. req0 SLL src2=1 shamt=31; rsp_ready=0 for 4 cycles
//      -> rsp_result=0x80000000 held stable and req_ready stays 0 until the handshake,
//         then IDLE on the next cycle.
//   5. req0 op=4'd13
//      -> rsp_err=1, rsp_result=0, rsp_zero=0.
//   6. rst asserted during EXEC with both requests pending
//      -> next cycle: IDLE, rsp_valid=0, alu_op=0; the first grant after reset goes to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALUOp codes, FSM states
// and the unsupported-op check.
package alu_pkg;

    localparam logic [3:0] ALU_NOP    = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_AND    = 4'd3;
    localparam logic [3:0] ALU_OR     = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_NOR    = 4'd6;
    localparam logic [3:0] ALU_SLT    = 4'd7;
    localparam logic [3:0] ALU_SLL    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_BEQ    = 4'd10;
    localparam logic [3:0] ALU_BNE    = 4'd11;
    localparam logic [3:0] ALU_OP_MAX = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Op 0 and everything above the last defined op are flagged as errors.
    function automatic logic isUnsupported(input logic [3:0] op);
        return (op == ALU_NOP) || (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping at
// NUM_REQ-1, and returns a one-hot grant plus the winning index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grantIdx
);

    logic          w_found;
    logic [ID_W:0] w_cand;

    // First requester at or after ptr (modulo NUM_REQ) wins.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req[w_cand[ID_W-1:0]]) begin
                w_found                     = 1'b1;
                grant[w_cand[ID_W-1:0]]     = 1'b1;
                grantIdx                    = w_cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. One operation at a
// time walks IDLE -> EXEC -> RESP; operands and results are registered.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int bit_size = 32,
    parameter  int NUM_REQ  = 2,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [4*NUM_REQ-1:0]        req_op,
    input  logic [bit_size*NUM_REQ-1:0] req_src1,
    input  logic [bit_size*NUM_REQ-1:0] req_src2,
    input  logic [5*NUM_REQ-1:0]        req_shamt,
    output logic [3:0]                  alu_op,
    output logic [bit_size-1:0]         alu_src1,
    output logic [bit_size-1:0]         alu_src2,
    output logic [4:0]                  alu_shamt,
    input  logic [bit_size-1:0]         alu_result,
    input  logic                        alu_zero,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [bit_size-1:0]         rsp_result,
    output logic                        rsp_zero,
    output logic                        rsp_err
);

    state_t                r_state;
    state_t                w_nextState;
    logic [ID_W-1:0]       r_rrPtr;
    logic [ID_W-1:0]       w_rrNext;

    logic [3:0]            r_op;
    logic [bit_size-1:0]   r_src1;
    logic [bit_size-1:0]   r_src2;
    logic [4:0]            r_shamt;
    logic [ID_W-1:0]       r_id;

    logic [ID_W-1:0]       r_rspId;
    logic [bit_size-1:0]   r_rspResult;
    logic                  r_rspZero;
    logic                  r_rspErr;

    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grantIdx;
    logic                  w_accept;

    logic [3:0]            w_opArr    [NUM_REQ];
    logic [bit_size-1:0]   w_src1Arr  [NUM_REQ];
    logic [bit_size-1:0]   w_src2Arr  [NUM_REQ];
    logic [4:0]            w_shamtArr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rrArbiter (
        .req      (req_valid),
        .ptr      (r_rrPtr),
        .grant    (w_grant),
        .grantIdx (w_grantIdx)
    );

    // Split the flattened request buses into per-requester slices.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_opArr[i]    = req_op[4*i +: 4];
            w_src1Arr[i]  = req_src1[bit_size*i +: bit_size];
            w_src2Arr[i]  = req_src2[bit_size*i +: bit_size];
            w_shamtArr[i] = req_shamt[5*i +: 5];
        end
    end

    assign w_accept  = (r_state == IDLE) && (|req_valid);
    assign w_rrNext  = (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + ID_W'(1);

    assign req_ready  = ((r_state == IDLE) && !rst) ? w_grant : '0;
    assign alu_op     = (r_state == EXEC) ? r_op : 4'd0;
    assign alu_src1   = r_src1;
    assign alu_src2   = r_src2;
    assign alu_shamt  = r_shamt;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_rspId;
    assign rsp_result = r_rspResult;
    assign rsp_zero   = r_rspZero;
    assign rsp_err    = r_rspErr;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|req_valid) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operand register loads on accept; response register and round-robin
    // pointer update once the ALU has produced its result in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr     <= '0;
            r_op        <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_shamt     <= '0;
            r_id        <= '0;
            r_rspId     <= '0;
            r_rspResult <= '0;
            r_rspZero   <= 1'b0;
            r_rspErr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_opArr[w_grantIdx];
                r_src1  <= w_src1Arr[w_grantIdx];
                r_src2  <= w_src2Arr[w_grantIdx];
                r_shamt <= w_shamtArr[w_grantIdx];
                r_id    <= w_grantIdx;
            end
            if (r_state == EXEC) begin
                r_rspId     <= r_id;
                r_rspResult <= alu_result;
                r_rspZero   <= alu_zero;
                r_rspErr    <= isUnsupported(r_op);
                r_rrPtr     <= w_rrNext;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with two requesters and a
// behavioural ALU model standing in for the real ALU.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int BitSize = 32;
    localparam int NumReq  = 2;
    localparam int IdW     = 1;

    logic                       clk;
    logic                       rst;
    logic [NumReq-1:0]          req_valid;
    logic [NumReq-1:0]          req_ready;
    logic [4*NumReq-1:0]        req_op;
    logic [BitSize*NumReq-1:0]  req_src1;
    logic [BitSize*NumReq-1:0]  req_src2;
    logic [5*NumReq-1:0]        req_shamt;
    logic [3:0]                 alu_op;
    logic [BitSize-1:0]         alu_src1;
    logic [BitSize-1:0]         alu_src2;
    logic [4:0]                 alu_shamt;
    logic [BitSize-1:0]         alu_result;
    logic                       alu_zero;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IdW-1:0]             rsp_id;
    logic [BitSize-1:0]         rsp_result;
    logic                       rsp_zero;
    logic                       rsp_err;

    typedef struct packed {
        logic [IdW-1:0]     id;
        logic [BitSize-1:0] result;
        logic               zero;
        logic               err;
    } rsp_t;

    rsp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;

    alu_share_arbiter #(
        .bit_size (BitSize),
        .NUM_REQ  (NumReq)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_shamt  (req_shamt),
        .alu_op     (alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure grant spacing.
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural ALU: unsupported ops return result 0, Zero 0.
    always_comb begin
        alu_result = '0;
        alu_zero   = 1'b0;
        case (alu_op)
            ALU_ADD: alu_result = alu_src1 + alu_src2;
            ALU_SUB: alu_result = alu_src1 - alu_src2;
            ALU_AND: alu_result = alu_src1 & alu_src2;
            ALU_OR:  alu_result = alu_src1 | alu_src2;
            ALU_XOR: alu_result = alu_src1 ^ alu_src2;
            ALU_NOR: alu_result = ~(alu_src1 | alu_src2);
            ALU_SLT: alu_result = ($signed(alu_src1) < $signed(alu_src2)) ? 32'd1 : 32'd0;
            ALU_SLL: alu_result = alu_src2 << alu_shamt;
            ALU_SRL: alu_result = alu_src2 >> alu_shamt;
            ALU_BEQ: alu_result = alu_src1 - alu_src2;
            ALU_BNE: alu_result = alu_src1 - alu_src2;
            default: alu_result = '0;
        endcase
        if (alu_op == ALU_BEQ) begin
            alu_zero = (alu_src1 == alu_src2);
        end else if (alu_op == ALU_BNE) begin
            alu_zero = (alu_src1 != alu_src2);
        end else if (alu_op >= ALU_ADD && alu_op <= ALU_SRL) begin
            alu_zero = (alu_result == '0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic pushExp(input int id, input logic [31:0] res, input logic zero, input logic err);
        rsp_t e;
        e.id     = IdW'(id);
        e.result = res;
        e.zero   = zero;
        e.err    = err;
        expQ.push_back(e);
    endtask

    // Issue one request on requester idx, wait for its grant, record the
    // expected response and drop valid after the transfer edge.
    task automatic applyStimulus(input int idx, input logic [3:0] op,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [4:0] sh, input logic [31:0] expRes,
                                 input logic expZero, input logic expErr);
        int waited = 0;
        @(negedge clk);
        req_op[idx*4 +: 4]          = op;
        req_src1[idx*BitSize +: BitSize] = s1;
        req_src2[idx*BitSize +: BitSize] = s2;
        req_shamt[idx*5 +: 5]       = sh;
        req_valid[idx]              = 1'b1;
        #1;
        while (req_ready[idx] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 20) begin
            timeoutFail("grant wait");
        end else begin
            checkOutput("req_ready one-hot", 32'(req_ready), 32'(1 << idx));
            pushExp(idx, expRes, expZero, expErr);
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        checkOutput("req_ready low in EXEC", 32'(req_ready), 32'd0);
    endtask

    // Wait until every expected response has been consumed by the monitor.
    task automatic drainQueue(input string name);
        int waited = 0;
        while (expQ.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (expQ.size() != 0) timeoutFail(name);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every completed response handshake against the queue.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    timeoutFail("unexpected response");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp_id",     32'(rsp_id),     32'(e.id));
                    checkOutput("rsp_result", rsp_result,      e.result);
                    checkOutput("rsp_zero",   32'(rsp_zero),   32'(e.zero));
                    checkOutput("rsp_err",    32'(rsp_err),    32'(e.err));
                end
            end
        end
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int grants;
        int lastCycle;
        int guard;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_src1  = '0;
        req_src2  = '0;
        req_shamt = '0;
        rsp_ready = 1'b1;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("reset rsp_id",     32'(rsp_id),     32'd0);
        checkOutput("reset rsp_result", rsp_result,      32'd0);
        checkOutput("reset rsp_zero",   32'(rsp_zero),   32'd0);
        checkOutput("reset rsp_err",    32'(rsp_err),    32'd0);
        checkOutput("reset req_ready",  32'(req_ready),  32'd0);
        checkOutput("reset alu_op",     32'(alu_op),     32'd0);
        checkOutput("reset alu_src1",   alu_src1,        32'd0);
        checkOutput("reset alu_src2",   alu_src2,        32'd0);
        checkOutput("reset alu_shamt",  32'(alu_shamt),  32'd0);
        rst = 1'b0;

        $display("[TB] test 1: req0 ADD 5+7, latency");
        applyStimulus(0, ALU_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0);
        checkOutput("t1 alu_op in EXEC",   32'(alu_op),    32'(ALU_ADD));
        checkOutput("t1 alu_src1",         alu_src1,       32'd5);
        checkOutput("t1 alu_src2",         alu_src2,       32'd7);
        checkOutput("t1 rsp_valid at T+1", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t1 rsp_valid at T+2", 32'(rsp_valid), 32'd1);
        checkOutput("t1 alu_op outside EXEC", 32'(alu_op), 32'd0);
        drainQueue("t1 drain");

        $display("[TB] test 3: req1 BEQ equal operands");
        applyStimulus(1, ALU_BEQ, 32'h55, 32'h55, 5'd0, 32'd0, 1'b1, 1'b0);
        drainQueue("t3 drain");

        $display("[TB] test 2: both valid, round-robin alternation");
        @(negedge clk);
        req_op[3:0]   = ALU_SUB;  req_src1[31:0]  = 32'd10;   req_src2[31:0]  = 32'd3;
        req_op[7:4]   = ALU_XOR;  req_src1[63:32] = 32'hF0;   req_src2[63:32] = 32'hFF;
        req_valid     = 2'b11;
        grants    = 0;
        lastCycle = -1;
        guard     = 0;
        while (grants < 4 && guard < 30) begin
            #1;
            if (req_ready != '0) begin
                checkOutput("t2 grant order", 32'(req_ready), (grants % 2 == 0) ? 32'd1 : 32'd2);
                if (lastCycle >= 0) checkOutput("t2 grant spacing", 32'(cycle - lastCycle), 32'd3);
                lastCycle = cycle;
                if (req_ready[0]) pushExp(0, 32'd7, 1'b0, 1'b0);
                else              pushExp(1, 32'h0F, 1'b0, 1'b0);
                grants++;
            end
            @(negedge clk);
            guard++;
        end
        if (grants < 4) timeoutFail("t2 grants");
        req_valid = '0;
        drainQueue("t2 drain");

        $display("[TB] test 4: SLL with response back-pressure");
        rsp_ready = 1'b0;
        applyStimulus(0, ALU_SLL, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
        req_op[7:4]     = ALU_ADD;
        req_src1[63:32] = 32'h10;
        req_src2[63:32] = 32'h20;
        req_shamt[9:5]  = 5'd0;
        req_valid[1]    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("t4 rsp_valid held",  32'(rsp_valid), 32'd1);
            checkOutput("t4 rsp_result held", rsp_result,     32'h8000_0000);
            checkOutput("t4 req_ready low",   32'(req_ready), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4 back to IDLE",   32'(rsp_valid), 32'd0);
        checkOutput("t4 req1 granted",   32'(req_ready), 32'd2);
        pushExp(1, 32'h30, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drainQueue("t4 drain");

        $display("[TB] test 5: unsupported op 13");
        applyStimulus(0, 4'd13, 32'd9, 32'd4, 5'd2, 32'd0, 1'b0, 1'b1);
        checkOutput("t5 op forwarded", 32'(alu_op), 32'd13);
        drainQueue("t5 drain");

        $display("[TB] test 6: reset during EXEC");
        @(negedge clk);
        req_op[3:0] = ALU_ADD; req_src1[31:0]  = 32'd1; req_src2[31:0]  = 32'd2;
        req_op[7:4] = ALU_ADD; req_src1[63:32] = 32'd3; req_src2[63:32] = 32'd4;
        req_valid   = 2'b11;
        #1;
        checkOutput("t6 pick before reset", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("t6 in EXEC", 32'(alu_op), 32'(ALU_ADD));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6 rsp_valid after reset", 32'(rsp_valid), 32'd0);
        checkOutput("t6 alu_op after reset",    32'(alu_op),    32'd0);
        checkOutput("t6 req_ready in reset",    32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t6 first grant after reset", 32'(req_ready), 32'd1);
        pushExp(0, 32'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        req_valid = '0;
        drainQueue("t6 drain");

        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
